// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: datapath width,
// iteration count, FSM encoding and a two's-complement magnitude helper.
package mult_div_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/mult_div_counter.sv
// Iteration counter for the multiply/divide sequencer; terminal flags the
// final iteration so the result can be committed on that same edge.
module mult_div_counter
    import mult_div_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/mult_div_unit.sv
// 32-cycle signed multiply (shift-add) / divide (restoring) unit with busy
// stall output and a one-cycle result-ready pulse.
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t               state, state_next;
    logic                 start;
    logic                 terminal;
    logic [CNT_W-1:0]     count;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 negate, b_zero;
    logic [2*WIDTH-1:0]   work;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, prod_s;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH+1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo, quo_s;
    logic                 mul_exc;

    mult_div_counter u_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (start),
        .enable   ((state == MULT) || (state == DIV)),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        unique case (state)
            IDLE: begin
                start = ctrl_MULT | ctrl_DIV;
                if (ctrl_MULT)     state_next = MULT;
                else if (ctrl_DIV) state_next = DIV;
            end
            MULT, DIV: if (terminal) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign data_resultRDY = (state == DONE);

    // work holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mag_a} : '0);
        mul_next  = {mul_sum, work[WIDTH-1:1]};
        prod_s    = negate ? (-mul_next) : mul_next;
        mul_exc   = (prod_s[2*WIDTH-1:WIDTH-1] != '0) && (prod_s[2*WIDTH-1:WIDTH-1] != '1);

        rem_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        div_diff  = {1'b0, rem_shift} - {2'b00, mag_b};
        div_next  = div_diff[WIDTH+1] ? {rem_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};
        quo       = div_next[WIDTH-1:0];
        quo_s     = negate ? (-quo) : quo;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mag_a          <= '0;
            mag_b          <= '0;
            negate         <= 1'b0;
            b_zero         <= 1'b0;
            work           <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            mag_a  <= magnitude(data_operandA);
            mag_b  <= magnitude(data_operandB);
            negate <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            b_zero <= (data_operandB == '0);
            work   <= ctrl_MULT ? {{WIDTH{1'b0}}, magnitude(data_operandB)}
                                : {{WIDTH{1'b0}}, magnitude(data_operandA)};
        end else if (state == MULT) begin
            work <= mul_next;
            if (terminal) begin
                data_result    <= prod_s[WIDTH-1:0];
                data_exception <= mul_exc;
            end
        end else if (state == DIV) begin
            work <= div_next;
            if (terminal) begin
                // a positive quotient with bit 31 set only arises from 0x80000000 / -1
                data_result    <= b_zero ? '0 : quo_s;
                data_exception <= b_zero | (~negate & quo[WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: result values, exception flag,
// ready latency, busy window, start priority and reset abort.
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    mult_div_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the next rising edge is the start edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic d, input int inject_at,
                          input logic [31:0] exp_res, input logic exp_exc,
                          input string tag);
        int          rdy_at   = 0;
        int          busy_cnt = 0;
        logic [31:0] cap_res  = 'x;
        logic        cap_exc  = 1'bx;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        for (int c = 1; c <= 40 && rdy_at == 0; c++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV  = 1'b0;
            if (c == inject_at) begin
                ctrl_DIV      = 1'b1;
                data_operandA = 32'd100;
                data_operandB = 32'd7;
            end
            if (busy) busy_cnt++;
            if (data_resultRDY) begin
                rdy_at  = c;
                cap_res = data_result;
                cap_exc = data_exception;
            end
        end
        check({tag, ".rdy_cycle"}, rdy_at, 33);
        check({tag, ".busy_cycles"}, busy_cnt, 33);
        check({tag, ".result"}, cap_res, exp_res);
        check({tag, ".exception"}, {31'd0, cap_exc}, {31'd0, exp_exc});
        @(negedge clock);
        check({tag, ".rdy_after"}, {31'd0, data_resultRDY}, 32'd0);
        check({tag, ".busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int rdy_seen;
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        #2 reset = 1'b1;
        #1;
        check("reset.result", data_result, 32'd0);
        check("reset.exception", {31'd0, data_exception}, 32'd0);
        check("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset.busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // start on the first edge after reset release
        run_op(32'd7,        32'hFFFFFFFD, 1'b1, 1'b0, 0, 32'hFFFFFFEB, 1'b0, "mul_7xm3");
        run_op(32'h00010000, 32'h00010000, 1'b1, 1'b0, 0, 32'h00000000, 1'b1, "mul_ovf");
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 0, 32'h80000000, 1'b1, "mul_min_m1");
        run_op(32'hFFFFFF9C, 32'd7,        1'b0, 1'b1, 0, 32'hFFFFFFF2, 1'b0, "div_m100_7");
        run_op(32'd5,        32'd0,        1'b0, 1'b1, 0, 32'h00000000, 1'b1, "div_by0");
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 0, 32'h80000000, 1'b1, "div_min_m1");
        run_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, 1'b1, 0, 32'h0000000E, 1'b0, "div_m100_m7");
        run_op(32'd6,        32'd3,        1'b1, 1'b1, 5, 32'd18,       1'b0, "both_prio");

        // abort a multiply at cycle 10
        data_operandA = 32'd3;
        data_operandB = 32'd5;
        ctrl_MULT = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.rdy", {31'd0, data_resultRDY}, 32'd0);
        check("abort.result", data_result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            if (data_resultRDY || busy) rdy_seen++;
        end
        check("abort.no_rdy", rdy_seen, 0);
        run_op(32'd20, 32'd4, 1'b0, 1'b1, 0, 32'd5, 1'b0, "div_20_4");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
